// File: rtl/fp24_pkg.sv
// rtl/fp24_pkg.sv - 24-bit float format: field widths, packed view and zero test.
package fp24_pkg;

  localparam int FP_N      = 24;
  localparam int FP_ES     = 6;
  localparam int FP_MANT_W = FP_N - 1 - FP_ES;

  typedef struct packed {
    logic                 sign;
    logic [FP_ES-1:0]     exp;
    logic [FP_MANT_W-1:0] mant;
  } fp24_t;

  // Signed zero counts as zero: only exponent and mantissa are inspected.
  function automatic logic is_zero(input fp24_t x);
    return (x.exp == '0) && (x.mant == '0);
  endfunction

endpackage

// File: rtl/fp_op_fifo.sv
// rtl/fp_op_fifo.sv - operand-pair FIFO with occupancy count; power-of-two DEPTH.
module fp_op_fifo
  import fp24_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * FP_N
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  assign w_push = i_push && (r_count != CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/fp_mult_issue_24b.sv
// rtl/fp_mult_issue_24b.sv - issues queued operand pairs to an external fp multiplier and registers products; FP_MULT_ISSUE_STATS_EN adds op_count.
module fp_mult_issue_24b
  import fp24_pkg::*;
#(
  parameter int N     = FP_N,
  parameter int ES    = FP_ES,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_a,
  input  logic [N-1:0]           in_b,
  output logic [N-1:0]           mul_a,
  output logic [N-1:0]           mul_b,
  input  logic [N-1:0]           mul_r,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_r,
  output logic                   out_zero,
  output logic [$clog2(DEPTH):0] fifo_count
`ifdef FP_MULT_ISSUE_STATS_EN
  ,
  output logic [31:0]            op_count
`endif
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int MANT_W = N - 1 - ES;

  logic [2*N-1:0] w_head;
  logic [CW-1:0]  w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_nonempty;
  logic           w_zero;
  logic           r_out_valid;
  logic [N-1:0]   r_out_r;
  logic           r_out_zero;

  fp_op_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * N)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({in_a, in_b}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready   = (w_count != CW'(DEPTH));
  assign w_nonempty = (w_count != '0);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_nonempty && (!r_out_valid || out_ready);

  assign mul_a = w_nonempty ? w_head[2*N-1:N] : '0;
  assign mul_b = w_nonempty ? w_head[N-1:0]   : '0;

  generate
    if ((N == FP_N) && (ES == FP_ES)) begin : g_pkg_zero
      assign w_zero = is_zero(mul_r);
    end else begin : g_gen_zero
      assign w_zero = (mul_r[N-2:MANT_W] == '0) && (mul_r[MANT_W-1:0] == '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_r     <= mul_r;
      r_out_zero  <= w_zero;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_r      = r_out_r;
  assign out_zero   = r_out_zero;
  assign fifo_count = w_count;

`ifdef FP_MULT_ISSUE_STATS_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (r_out_valid && out_ready) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_fp_mult_issue_24b.sv
// tb/tb_fp_mult_issue_24b.sv - directed bench for fp_mult_issue_24b with a behavioural multiplier.
module tb_fp_mult_issue_24b;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_a;
  logic [23:0] in_b;
  logic [23:0] mul_a;
  logic [23:0] mul_b;
  logic [23:0] mul_r;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_r;
  logic        out_zero;
  logic [2:0]  fifo_count;
`ifdef FP_MULT_ISSUE_STATS_EN
  logic [31:0] op_count;
`endif

  int n_vec;
  int n_err;

  fp_mult_issue_24b #(.N(24), .ES(6), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_r      (mul_r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_zero   (out_zero),
    .fifo_count (fifo_count)
`ifdef FP_MULT_ISSUE_STATS_EN
    ,
    .op_count   (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating multiply: bias 31, hidden one, flush underflow to signed zero, saturate overflow.
  function automatic logic [23:0] fmul(input logic [23:0] a, input logic [23:0] b);
    logic        s;
    int          e;
    logic [35:0] p;
    logic [16:0] m;
    s = a[23] ^ b[23];
    if (a[22:0] == 23'd0 || b[22:0] == 23'd0) return {s, 23'd0};
    p = 36'({1'b1, a[16:0]}) * 36'({1'b1, b[16:0]});
    e = int'(a[22:17]) + int'(b[22:17]) - 31;
    if (p[35]) begin
      m = p[34:18];
      e = e + 1;
    end else begin
      m = p[33:17];
    end
    if (e <= 0) return {s, 23'd0};
    if (e >= 63) return {s, 6'h3f, 17'h1ffff};
    return {s, e[5:0], m};
  endfunction

  always_comb mul_r = fmul(mul_a, mul_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #3;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_vec++;
    if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_vec++;
    if (out_r !== 24'h0 || out_zero !== 1'b0) begin
      n_err++; $display("FAIL reset_out got %h/%0b want 000000/0", out_r, out_zero);
    end
    n_vec++;
    if (mul_a !== 24'h0 || mul_b !== 24'h0) begin
      n_err++; $display("FAIL reset_mul got %h/%h want 000000/000000", mul_a, mul_b);
    end
    tick();
  endtask

  task automatic test_first_push();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 24'h0A0000;
    in_b      = 24'h0A0000;
    tick();
    in_a = 24'h3E0000;
    in_b = 24'h3F0000;
    n_vec++;
    if (mul_a !== 24'h0A0000 || mul_b !== 24'h0A0000) begin
      n_err++; $display("FAIL first_mul got %h/%h want 0a0000/0a0000", mul_a, mul_b);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_early_valid got %0b want 0", out_valid); end
    tick();
    in_a = 24'h3F0000;
    in_b = 24'h3F0000;
    n_vec++;
    if (out_valid !== 1'b1 || out_r !== 24'h000000 || out_zero !== 1'b1) begin
      n_err++; $display("FAIL first_out got %0b/%h/%0b want 1/000000/1", out_valid, out_r, out_zero);
    end
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_r !== 24'h3F0000 || out_zero !== 1'b0) begin
      n_err++; $display("FAIL b2b_one_p5 got %0b/%h/%0b want 1/3f0000/0", out_valid, out_r, out_zero);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_r !== 24'h404000) begin
      n_err++; $display("FAIL b2b_p5_sq got %0b/%h want 1/404000", out_valid, out_r);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++; $display("FAIL b2b_drain got %0b/%0d want 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] a_v [6];
    logic [23:0] b_v [6];
    int got;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      a_v[k] = 24'h3E0000 + 24'(k * 24'h4321);
      b_v[k] = 24'h400000 - 24'(k * 24'h1234);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_a = a_v[k];
      in_b = b_v[k];
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_%0d got %0b want 1", k, in_ready); end
      tick();
    end
    n_vec++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_full got cnt=%0d rdy=%0b ov=%0b want 4/0/1", fifo_count, in_ready, out_valid);
    end
    in_a = a_v[5];
    in_b = b_v[5];
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_vec++;
        if (got >= 5) begin
          n_err++; $display("FAIL bp_extra got %h want none", out_r);
        end else if (out_r !== fmul(a_v[got], b_v[got])) begin
          n_err++; $display("FAIL bp_order_%0d got %h want %h", got, out_r, fmul(a_v[got], b_v[got]));
        end
        got++;
      end
      tick();
      if (c == 0) begin
        in_valid = 1'b0;
        n_vec++;
        if (fifo_count !== 3'd3) begin
          n_err++; $display("FAIL bp_full_pop_nopush got %0d want 3", fifo_count);
        end
      end
    end
    n_vec++;
    if (got !== 5 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_total got %0d/%0b want 5/0", got, out_valid);
    end
  endtask

  task automatic test_stream();
    logic [23:0] exp_q[$];
    logic [23:0] e;
    int got;
    do_reset();
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 110; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        in_a = 24'($urandom);
        in_b = 24'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(fmul(in_a, in_b));
      if (i >= 2 && i < 102) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_gap cycle %0d got 0 want 1", i); end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra got %h want none", out_r);
        end else begin
          e = exp_q.pop_front();
          if (out_r !== e || out_zero !== (e[22:0] == 23'd0)) begin
            n_err++; $display("FAIL stream_%0d got %h/%0b want %h/%0b", got, out_r, out_zero, e, e[22:0] == 23'd0);
          end
        end
        got++;
      end
      tick();
    end
    n_vec++;
    if (got !== 100) begin n_err++; $display("FAIL stream_count got %0d want 100", got); end
  endtask

  task automatic test_neg_zero_hold();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 24'h800000;
    in_b      = 24'h123456;
    tick();
    in_valid = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_r !== 24'h800000 || out_zero !== 1'b1) begin
        n_err++; $display("FAIL negzero_hold_%0d got %0b/%h/%0b want 1/800000/1", c, out_valid, out_r, out_zero);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_a = 24'h3E0000 + 24'(k);
      in_b = 24'h3E0000;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL rmid_pre got %0d/%0b want 3/1", fifo_count, out_valid);
    end
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rmid_async got %0b/%0d/%0b want 0/0/1", out_valid, fifo_count, in_ready);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_stale got %h want none", out_r); end
    end
  endtask

`ifdef FP_MULT_ISSUE_STATS_EN
  task automatic test_stats();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_a = 24'h3E0000;
      in_b = 24'h3E0000 + 24'(k);
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    n_vec++;
    if (op_count !== 32'd7) begin n_err++; $display("FAIL stats_count got %0d want 7", op_count); end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_first_push();
    test_backpressure();
    test_stream();
    test_neg_zero_hold();
    test_reset_mid();
`ifdef FP_MULT_ISSUE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
